// File: rtl/booth_mul_seq_if.sv
// Request/response bundle for the iterative Booth multiplier.
// The master side issues ops and drains results; the slave side is the multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_signed;
    logic             b_signed;
    logic             hi_sel;
    logic             word;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, a, b, a_signed, b_signed, hi_sel, word,
        output flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, hi_sel, word,
        input  flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Radix-4 Booth multiplier sequencer for the RV64 M-extension MUL unit.
// Retires one Booth digit per cycle into a double-width accumulator.
module booth_mul_seq #(
    parameter int WIDTH = 64
) (
    input logic             clk,
    input logic             rst,
    booth_mul_seq_if.slave  io
);
    localparam int EW   = WIDTH + 2;
    localparam int ITER = EW / 2;
    localparam int AW   = 2 * WIDTH;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   mc_q, mc_d;
    logic [EW:0]     mp_q, mp_d;
    logic            word_q, word_d;
    logic            hi_q, hi_d;

    logic [WIDTH-1:0] a_op, b_op;
    logic             a_sx, b_sx;
    logic [EW-1:0]    a_ext, b_ext;
    logic [AW-1:0]    pp;
    logic             last;

    // MULW sign-extends the low words and forces signed operands
    always_comb begin
        a_op = io.a;
        b_op = io.b;
        a_sx = io.a_signed & io.a[WIDTH-1];
        b_sx = io.b_signed & io.b[WIDTH-1];
        if (io.word) begin
            a_op = {{(WIDTH-32){io.a[31]}}, io.a[31:0]};
            b_op = {{(WIDTH-32){io.b[31]}}, io.b[31:0]};
            a_sx = io.a[31];
            b_sx = io.b[31];
        end
        a_ext = {{2{a_sx}}, a_op};
        b_ext = {{2{b_sx}}, b_op};
    end

    // mc_q holds Aext pre-shifted by 2i; mp_q[2:0] is the current digit window
    always_comb begin
        pp = '0;
        unique case (mp_q[2:0])
            3'b001, 3'b010: pp = mc_q;
            3'b011:         pp = mc_q << 1;
            3'b100:         pp = -(mc_q << 1);
            3'b101, 3'b110: pp = -mc_q;
            default:        pp = '0;
        endcase
    end

    assign last = (cnt_q == CW'(ITER - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        word_d  = word_q;
        hi_d    = hi_q;
        if (io.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        state_d = CALC;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mc_d    = {{(AW-EW){a_ext[EW-1]}}, a_ext};
                        mp_d    = {b_ext, 1'b0};
                        word_d  = io.word;
                        hi_d    = io.hi_sel & ~io.word;
                    end
                end
                CALC: begin
                    acc_d = acc_q + pp;
                    mc_d  = mc_q << 2;
                    mp_d  = {2'b00, mp_q[EW:2]};
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = DONE;
                end
                DONE: begin
                    if (io.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            word_q  <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            word_q  <= word_d;
            hi_q    <= hi_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);

    always_comb begin
        if (word_q)    io.result = {{(WIDTH-32){acc_q[31]}}, acc_q[31:0]};
        else if (hi_q) io.result = acc_q[AW-1:WIDTH];
        else           io.result = acc_q[WIDTH-1:0];
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a cycle-level reference model.
// Literal expectations pin the arithmetic; the monitor checks every cycle.
module tb_booth_mul_seq;
    localparam int W    = 64;
    localparam int ITER = (W + 2) / 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    booth_mul_seq_if #(.WIDTH(W)) bus ();

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mdl(input logic [63:0] a, input logic [63:0] b,
                                        input logic as, input logic bs,
                                        input logic hi, input logic w);
        logic [127:0] x, y, p;
        if (w) begin
            x = {{96{a[31]}}, a[31:0]};
            y = {{96{b[31]}}, b[31:0]};
            p = x * y;
            return {{32{p[31]}}, p[31:0]};
        end
        x = as ? {{64{a[63]}}, a} : {64'd0, a};
        y = bs ? {{64{b[63]}}, b} : {64'd0, b};
        p = x * y;
        return hi ? p[127:64] : p[63:0];
    endfunction

    // Reference: op-level behaviour counted in cycles since accept
    logic        m_busy;
    logic        m_done;
    int          m_cnt;
    logic [63:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_result", bus.result, 64'd0);
        end else begin
            chk("mon_out_valid", 64'(bus.out_valid), 64'(m_done));
            chk("mon_in_ready", 64'(bus.in_ready), 64'(!m_busy && !m_done));
            chk("mon_busy", 64'(bus.busy), 64'(m_busy || m_done));
            if (m_done) chk("mon_result", bus.result, m_exp);
            if (bus.flush) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (m_done) begin
                if (bus.out_ready) m_done = 1'b0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == ITER) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (bus.in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_exp  = mdl(bus.a, bus.b, bus.a_signed, bus.b_signed,
                             bus.hi_sel, bus.word);
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic as, input logic bs,
                         input logic hi, input logic w);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.a_signed = as;
        bus.b_signed = bs;
        bus.hi_sel   = hi;
        bus.word     = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [63:0] a,
                          input logic [63:0] b, input logic as,
                          input logic bs, input logic hi, input logic w,
                          input logic [63:0] lit, input int hold);
        int lat;
        bus.out_ready = (hold == 0);
        issue(a, b, as, bs, hi, w);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(ITER + 1));
        chk({nm, "_result"}, bus.result, lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold_result"}, bus.result, lit);
            chk({nm, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, "_idle_after"}, 64'(bus.in_ready), 64'd1);
        chk({nm, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic watch_quiet(input string nm, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk({nm, "_no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.a_signed  = 1'b0;
        bus.b_signed  = 1'b0;
        bus.hi_sel    = 1'b0;
        bus.word      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mulhu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b1, 1'b0,
               64'h1, 0);
        run_op("mul", -64'sd3, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("mulh", -64'sd3, 64'd7, 1'b1, 1'b1, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulh_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               1'b1, 1'b1, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 0);
        run_op("mulw", 64'h1_7FFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mulhu_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mul_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b0, 1'b0, 64'h1, 0);
        run_op("mulhu_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               1'b0, 1'b0, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 0);
        run_op("mulhsu_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               1'b1, 1'b0, 1'b1, 1'b0, 64'hC000_0000_0000_0000, 0);

        // Back-pressure then immediate back-to-back accept
        run_op("hold", 64'd12345, 64'd1000, 1'b1, 1'b1, 1'b0, 1'b0,
               64'd12345000, 10);
        run_op("b2b", 64'd6, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0, 64'd42, 0);

        // Flush together with a request in IDLE: not accepted
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_idle_busy", 64'(bus.busy), 64'd0);

        // Flush at CALC cycle 5
        issue(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_calc_busy", 64'(bus.busy), 64'd0);
        watch_quiet("flush", ITER + 5);
        run_op("post_flush", 64'd9, 64'd11, 1'b0, 1'b0, 1'b0, 1'b0, 64'd99, 0);

        // Async reset at cycle 20 of an op
        issue(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_result", bus.result, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        watch_quiet("rst", ITER + 5);
        run_op("post_rst", -64'sd4, -64'sd5, 1'b1, 1'b1, 1'b0, 1'b0, 64'd20, 0);

        // Flush coincident with the result handshake
        bus.out_ready = 1'b1;
        issue(64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (ITER) @(posedge clk);
        #1;
        chk("flush_hs_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_hs_idle", 64'(bus.in_ready), 64'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
